// File: rtl/host_cfg_sequencer_if.sv
// Descriptor stream plus host_controller bus between the host/DMA side and the sequencer.
// The master side feeds descriptors and abort. The slave side drives the array bus and status.
interface host_cfg_sequencer_if #(
  parameter int INST_W   = 48,
  parameter int PE_SEL_W = 13
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [63:0]                  cfg_data;
  logic                         abort;
  logic [INST_W+PE_SEL_W+1:0]   host_controller;
  logic                         busy;
  logic                         done;
  logic                         err;

  modport master (
    output cfg_valid, cfg_data, abort,
    input  cfg_ready, host_controller, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_data, abort,
    output cfg_ready, host_controller, busy, done, err
  );
endinterface

// File: rtl/host_cfg_sequencer.sv
// Replays config descriptors as one-cycle init_SPM / init_PE_array strobes on the CGRA host bus.
// A RUN descriptor then holds run high for a programmed number of cycles.
module host_cfg_sequencer #(
  parameter int INST_W    = 48,
  parameter int PE_SEL_W  = 13,
  parameter int RUN_CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  host_cfg_sequencer_if.slave bus
);
  localparam int HC_W = INST_W + PE_SEL_W + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [RUN_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HC_W-1:0]        hc_q, hc_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic [1:0]             op;
  logic [PE_SEL_W-1:0]    pe_mask;
  logic [INST_W-1:0]      payload;
  logic [RUN_CNT_W-1:0]   run_n;

  assign accept  = bus.cfg_valid & cfg_ready_q;
  assign op      = bus.cfg_data[63:62];
  assign pe_mask = bus.cfg_data[INST_W +: PE_SEL_W];
  assign payload = bus.cfg_data[INST_W-1:0];
  assign run_n   = bus.cfg_data[RUN_CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hc_d        = '0;
    cfg_ready_d = cfg_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (accept) begin
          unique case (op)
            2'b00: hc_d = {1'b0, 1'b1, {PE_SEL_W{1'b0}}, payload};
            2'b01: begin
              if (pe_mask == '0) err_d = 1'b1;
              else               hc_d  = {1'b0, 1'b0, pe_mask, payload};
            end
            2'b10: begin
              if (run_n == '0) begin
                done_d = 1'b1;
              end else begin
                state_d        = RUN;
                cnt_d          = run_n;
                hc_d[HC_W-1]   = 1'b1;
                busy_d         = 1'b1;
                cfg_ready_d    = 1'b0;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      RUN: begin
        // cnt_q == 1 means the cycle now showing run is the last one
        if (bus.abort || cnt_q == RUN_CNT_W'(1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cfg_ready_d = 1'b1;
        end else begin
          cnt_d        = cnt_q - RUN_CNT_W'(1);
          hc_d[HC_W-1] = 1'b1;
          busy_d       = 1'b1;
          cfg_ready_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hc_q        <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hc_q        <= hc_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cfg_ready       = cfg_ready_q;
  assign bus.host_controller = hc_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
endmodule
